// File: rtl/icache_refill_router.sv
// Routes icache line refills to one of NUM_TGT sources by base/mask windows, returns the line, flags unmapped/timeouts.
// Latency: request pulse 1 cycle after req_valid_i, line 1 cycle after the selected response (unmapped error after 2 cycles).
// Backpressure: one refill in flight; busy_o high until it retires, extra requests and stray responses are counted and dropped.
module icache_refill_router #(
    parameter int unsigned                 NUM_TGT        = 2,
    parameter int unsigned                 ADDR_W         = 40,
    parameter int unsigned                 DATA_W         = 128,
    parameter logic [NUM_TGT*ADDR_W-1:0]   TGT_BASE       = {40'h0, 40'h0},
    parameter logic [NUM_TGT*ADDR_W-1:0]   TGT_MASK       = {40'h0, 40'hFF_FF00_0000},
    parameter int unsigned                 TIMEOUT_CYCLES = 1024
) (
    input  logic                        clk_i,
    input  logic                        rstn_i,
    input  logic                        req_valid_i,
    input  logic [ADDR_W-1:0]           req_paddr_i,
    input  logic                        kill_i,
    output logic                        busy_o,
    output logic [NUM_TGT-1:0]          tgt_req_valid_o,
    output logic [ADDR_W-1:0]           tgt_req_addr_o,
    input  logic [NUM_TGT-1:0]          tgt_resp_valid_i,
    input  logic [NUM_TGT*DATA_W-1:0]   tgt_resp_data_i,
    output logic                        resp_valid_o,
    output logic [DATA_W-1:0]           resp_data_o,
    output logic                        resp_error_o,
    output logic [15:0]                 spurious_cnt_o,
    output logic [15:0]                 timeout_cnt_o
);

    localparam int unsigned      CNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam int unsigned      SPW      = $clog2(NUM_TGT + 2);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP,
        DRAIN
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_TGT-1:0]   sel_q, sel_d;
    logic                 unmapped_q, unmapped_d;
    logic [CNT_W-1:0]     tmo_q, tmo_d;

    logic [NUM_TGT-1:0]   hit, hit_first;
    logic [NUM_TGT-1:0]   tgt_req_d;
    logic [ADDR_W-1:0]    addr_d;
    logic                 resp_valid_d, resp_error_d;
    logic [DATA_W-1:0]    resp_data_d, sel_data;
    logic [15:0]          spur_d, tmo_cnt_d;
    logic [16:0]          spur_sum;
    logic [SPW-1:0]       spur_inc;
    logic [NUM_TGT-1:0]   bad_resp;
    logic                 sel_resp, tmo_expire, in_window;

    // Address decode; lowest matching window wins
    always_comb begin
        hit = '0;
        for (int i = 0; i < NUM_TGT; i++) begin
            hit[i] = ((req_paddr_i & TGT_MASK[i*ADDR_W +: ADDR_W]) == TGT_BASE[i*ADDR_W +: ADDR_W]);
        end
        hit_first = hit & (~hit + NUM_TGT'(1));
    end

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_TGT; i++) begin
            if (sel_q[i]) begin
                sel_data = sel_data | tgt_resp_data_i[i*DATA_W +: DATA_W];
            end
        end
    end

    assign sel_resp   = |(tgt_resp_valid_i & sel_q);
    assign tmo_expire = (tmo_q == TMO_LAST);
    assign in_window  = (state_q == ISSUE) || (state_q == WAIT) || (state_q == DRAIN);

    // The selected target's response is never stray while a refill is outstanding, even when killed
    always_comb begin
        bad_resp = in_window ? (tgt_resp_valid_i & ~sel_q) : tgt_resp_valid_i;
        spur_inc = SPW'(req_valid_i && (state_q != IDLE));
        for (int i = 0; i < NUM_TGT; i++) begin
            spur_inc = spur_inc + SPW'(bad_resp[i]);
        end
        spur_sum = {1'b0, spurious_cnt_o} + 17'(spur_inc);
        spur_d   = spur_sum[16] ? 16'hFFFF : spur_sum[15:0];
    end

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        unmapped_d   = unmapped_q;
        tmo_d        = '0;
        tgt_req_d    = '0;
        addr_d       = tgt_req_addr_o;
        resp_valid_d = 1'b0;
        resp_error_d = 1'b0;
        resp_data_d  = resp_data_o;
        tmo_cnt_d    = timeout_cnt_o;

        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    addr_d = req_paddr_i;
                    if (|hit) begin
                        sel_d      = hit_first;
                        tgt_req_d  = hit_first;
                        unmapped_d = 1'b0;
                        state_d    = ISSUE;
                    end else begin
                        sel_d      = '0;
                        unmapped_d = 1'b1;
                        state_d    = RESP;
                    end
                end
            end
            ISSUE: begin
                if (sel_resp) begin
                    if (kill_i) begin
                        state_d = IDLE;
                    end else begin
                        resp_valid_d = 1'b1;
                        resp_data_d  = sel_data;
                        state_d      = RESP;
                    end
                end else begin
                    state_d = kill_i ? DRAIN : WAIT;
                end
            end
            WAIT: begin
                if (sel_resp) begin
                    if (kill_i) begin
                        state_d = IDLE;
                    end else begin
                        resp_valid_d = 1'b1;
                        resp_data_d  = sel_data;
                        state_d      = RESP;
                    end
                end else if (tmo_expire) begin
                    if (kill_i) begin
                        state_d = IDLE;
                    end else begin
                        resp_valid_d = 1'b1;
                        resp_error_d = 1'b1;
                        resp_data_d  = '0;
                        tmo_cnt_d    = (timeout_cnt_o == 16'hFFFF) ? timeout_cnt_o : timeout_cnt_o + 16'd1;
                        state_d      = RESP;
                    end
                end else begin
                    // The drain keeps the same budget so a killed refill retires no later than a live one
                    tmo_d = tmo_q + CNT_W'(1);
                    if (kill_i) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (sel_resp || tmo_expire) begin
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + CNT_W'(1);
                end
            end
            RESP: begin
                // Unmapped errors spend one staging cycle here, which is the only window where a kill can still cancel the line
                if (unmapped_q) begin
                    unmapped_d = 1'b0;
                    if (kill_i) begin
                        state_d = IDLE;
                    end else begin
                        resp_valid_d = 1'b1;
                        resp_error_d = 1'b1;
                        resp_data_d  = '0;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q         <= IDLE;
            sel_q           <= '0;
            unmapped_q      <= 1'b0;
            tmo_q           <= '0;
            busy_o          <= 1'b0;
            tgt_req_valid_o <= '0;
            tgt_req_addr_o  <= '0;
            resp_valid_o    <= 1'b0;
            resp_error_o    <= 1'b0;
            resp_data_o     <= '0;
            spurious_cnt_o  <= '0;
            timeout_cnt_o   <= '0;
        end else begin
            state_q         <= state_d;
            sel_q           <= sel_d;
            unmapped_q      <= unmapped_d;
            tmo_q           <= tmo_d;
            busy_o          <= (state_d != IDLE);
            tgt_req_valid_o <= tgt_req_d;
            tgt_req_addr_o  <= addr_d;
            resp_valid_o    <= resp_valid_d;
            resp_error_o    <= resp_error_d;
            resp_data_o     <= resp_data_d;
            spurious_cnt_o  <= spur_d;
            timeout_cnt_o   <= tmo_cnt_d;
        end
    end

endmodule

// File: tb/tb_icache_refill_router.sv
// Randomized scoreboard bench for icache_refill_router: driver queues expected target pulses and lines, a monitor pops and compares.
module tb_icache_refill_router;

    localparam int NT  = 3;
    localparam int AW  = 40;
    localparam int DW  = 128;
    localparam int TMO = 8;
    localparam logic [NT*AW-1:0] BASE = {40'h00_8000_0000, 40'h00_8000_0000, 40'h00_0000_0000};
    localparam logic [NT*AW-1:0] MASK = {40'hFF_8000_0000, 40'hFF_C000_0000, 40'hFF_FF00_0000};

    typedef struct {
        int            cyc;
        logic [DW-1:0] data;
        logic          err;
    } rsp_t;

    typedef struct {
        int            cyc;
        logic [NT-1:0] oh;
        logic [AW-1:0] addr;
    } req_t;

    logic             tb_clk;
    logic             tb_rstn;
    logic             req_valid;
    logic [AW-1:0]    paddr;
    logic             kill;
    logic             busy;
    logic [NT-1:0]    tgt_req_valid;
    logic [AW-1:0]    tgt_req_addr;
    logic [NT-1:0]    resp_vld;
    logic [NT*DW-1:0] resp_dat;
    logic             resp_valid;
    logic [DW-1:0]    resp_data;
    logic             resp_error;
    logic [15:0]      spurious_cnt;
    logic [15:0]      timeout_cnt;

    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   busy_lo = 1;
    int   busy_hi = 0;
    int   exp_spur = 0;
    int   exp_tmo = 0;
    bit   mon_en = 0;
    rsp_t exp_resp[$];
    req_t exp_req[$];
    rsp_t mon_rsp;
    req_t mon_req;

    icache_refill_router #(
        .NUM_TGT(NT), .ADDR_W(AW), .DATA_W(DW),
        .TGT_BASE(BASE), .TGT_MASK(MASK), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_i(tb_clk),
        .rstn_i(tb_rstn),
        .req_valid_i(req_valid),
        .req_paddr_i(paddr),
        .kill_i(kill),
        .busy_o(busy),
        .tgt_req_valid_o(tgt_req_valid),
        .tgt_req_addr_o(tgt_req_addr),
        .tgt_resp_valid_i(resp_vld),
        .tgt_resp_data_i(resp_dat),
        .resp_valid_o(resp_valid),
        .resp_data_o(resp_data),
        .resp_error_o(resp_error),
        .spurious_cnt_o(spurious_cnt),
        .timeout_cnt_o(timeout_cnt)
    );

    initial tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;
    always @(posedge tb_clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    // Address map in plain ranges: bootrom below 16 MiB, L2 at 2..3 GiB, third source 3..4 GiB, everything else unmapped
    function automatic int decode(input logic [AW-1:0] a);
        if (a < 40'h00_0100_0000) return 0;
        if (a >= 40'h00_8000_0000 && a < 40'h00_C000_0000) return 1;
        if (a >= 40'h00_C000_0000 && a < 40'h01_0000_0000) return 2;
        return -1;
    endfunction

    function automatic logic [DW-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        logic [AW-1:0] a;
        case ($urandom_range(0, 3))
            0:       a = {16'h0, 24'($urandom)};
            1:       a = 40'h00_8000_0000 | {10'h0, 30'($urandom)};
            2:       a = 40'h00_C000_0000 | {10'h0, 30'($urandom)};
            default: a = {8'($urandom), 32'($urandom)};
        endcase
        return a;
    endfunction

    task automatic clear_inputs();
        req_valid = 1'b0;
        paddr     = '0;
        kill      = 1'b0;
        resp_vld  = '0;
        resp_dat  = '0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge tb_clk); #1;
            clear_inputs();
        end
    endtask

    // One refill: d = cycles from the target pulse to its response, kk = cycle offset of kill from the pulse
    task automatic do_txn(input logic [AW-1:0] addr, input int d, input bit kill_en, input int kk,
                          input bit extra, input bit spreq, input logic [DW-1:0] dat);
        int   tgt, oth, t0, p, hi, last;
        bit   acc;
        rsp_t er;
        req_t eq;
        tgt = decode(addr);
        oth = (tgt == 0) ? 1 : 0;
        @(posedge tb_clk); #1;
        t0  = cyc;
        p   = t0 + 1;
        acc = (d <= TMO);
        if (tgt < 0) begin
            hi = kill_en ? t0 + 1 : t0 + 2;
            if (!kill_en) begin
                er.cyc = t0 + 2; er.data = '0; er.err = 1'b1;
                exp_resp.push_back(er);
            end
            last = hi;
        end else begin
            eq.cyc = p; eq.oh = NT'(1) << tgt; eq.addr = addr;
            exp_req.push_back(eq);
            if (kill_en) begin
                hi = acc ? p + d : p + TMO;
            end else if (acc) begin
                hi = p + d + 1;
                er.cyc = hi; er.data = dat; er.err = 1'b0;
                exp_resp.push_back(er);
            end else begin
                hi = p + TMO + 1;
                er.cyc = hi; er.data = '0; er.err = 1'b1;
                exp_resp.push_back(er);
                exp_tmo++;
            end
            if (!acc)  exp_spur++;
            if (extra) exp_spur++;
            if (spreq) exp_spur++;
            last = (hi > p + d) ? hi : p + d;
        end
        busy_lo = t0 + 1;
        busy_hi = hi;
        for (int c = t0; c <= last; c++) begin
            if (c != t0) begin
                @(posedge tb_clk); #1;
            end
            clear_inputs();
            if (c == t0) begin
                req_valid = 1'b1;
                paddr     = addr;
            end
            if (tgt >= 0) begin
                if (spreq && c == t0 + 1) begin
                    req_valid = 1'b1;
                    paddr     = rand_addr();
                end
                if (kill_en && c == p + kk) kill = 1'b1;
                if (c == p + d) begin
                    resp_vld[tgt]           = 1'b1;
                    resp_dat[tgt*DW +: DW]  = dat;
                    if (extra) begin
                        resp_vld[oth]          = 1'b1;
                        resp_dat[oth*DW +: DW] = rnd128();
                    end
                end
            end else if (kill_en && c == t0 + 1) begin
                kill = 1'b1;
            end
        end
    endtask

    always @(negedge tb_clk) begin
        if (mon_en && tb_rstn) begin
            chk("busy", DW'(busy), DW'(cyc >= busy_lo && cyc <= busy_hi));
            if (tgt_req_valid != '0) begin
                if (exp_req.size() == 0) begin
                    chk("unexpected_tgt_req", DW'(tgt_req_valid), '0);
                end else begin
                    mon_req = exp_req.pop_front();
                    chk("tgt_req_cycle", DW'(cyc), DW'(mon_req.cyc));
                    chk("tgt_req_onehot", DW'(tgt_req_valid), DW'(mon_req.oh));
                    chk("tgt_req_addr", DW'(tgt_req_addr), DW'(mon_req.addr));
                end
            end
            if (resp_valid) begin
                if (exp_resp.size() == 0) begin
                    chk("unexpected_resp", DW'(resp_valid), '0);
                end else begin
                    mon_rsp = exp_resp.pop_front();
                    chk("resp_cycle", DW'(cyc), DW'(mon_rsp.cyc));
                    chk("resp_data", resp_data, mon_rsp.data);
                    chk("resp_error", DW'(resp_error), DW'(mon_rsp.err));
                end
            end
        end
    end

    task automatic check_counters(input string tag);
        chk({tag, "_spurious_cnt"}, DW'(spurious_cnt), DW'(exp_spur));
        chk({tag, "_timeout_cnt"}, DW'(timeout_cnt), DW'(exp_tmo));
        chk({tag, "_resp_queue_empty"}, DW'(exp_resp.size()), '0);
        chk({tag, "_req_queue_empty"}, DW'(exp_req.size()), '0);
    endtask

    initial begin
        int            d, kk;
        bit            ke, ex, sp;
        logic [AW-1:0] a;
        tb_rstn = 1'b0;
        clear_inputs();
        #3;
        chk("reset_busy", DW'(busy), '0);
        chk("reset_tgt_req", DW'(tgt_req_valid), '0);
        chk("reset_tgt_addr", DW'(tgt_req_addr), '0);
        chk("reset_resp_valid", DW'(resp_valid), '0);
        chk("reset_resp_error", DW'(resp_error), '0);
        chk("reset_resp_data", resp_data, '0);
        chk("reset_spurious_cnt", DW'(spurious_cnt), '0);
        chk("reset_timeout_cnt", DW'(timeout_cnt), '0);
        idle(2);
        tb_rstn = 1'b1;
        mon_en  = 1'b1;
        idle(2);

        do_txn(40'h100, 3, 0, 0, 0, 0, {16{8'hA5}});
        do_txn(40'h00_8000_0000, 0, 0, 0, 0, 0, rnd128());
        do_txn(40'h00_4000_0000, 0, 0, 0, 0, 0, rnd128());
        do_txn(40'h200, TMO + 2, 0, 0, 0, 0, rnd128());
        do_txn(40'h300, 4, 1, 2, 0, 0, rnd128());
        do_txn(40'h340, 1, 0, 0, 0, 0, rnd128());
        do_txn(40'h00_8000_0100, 2, 0, 0, 1, 0, rnd128());
        do_txn(40'h00_C000_0040, TMO, 0, 0, 0, 0, rnd128());
        do_txn(40'h00_4000_0000, 0, 1, 0, 0, 0, rnd128());
        do_txn(40'h00_8000_0200, 1, 0, 0, 0, 1, rnd128());
        idle(2);
        check_counters("directed");

        for (int n = 0; n < 80; n++) begin
            a  = rand_addr();
            d  = $urandom_range(0, TMO + 2);
            ke = ($urandom_range(0, 3) == 0);
            kk = $urandom_range(0, (d < TMO) ? d : TMO);
            ex = ($urandom_range(0, 3) == 0);
            sp = ($urandom_range(0, 3) == 0);
            do_txn(a, d, ke, kk, ex, sp, rnd128());
            idle($urandom_range(0, 2));
        end
        idle(2);
        check_counters("random");

        // Asynchronous reset while a refill sits in WAIT
        mon_en = 1'b0;
        @(posedge tb_clk); #1;
        clear_inputs();
        req_valid = 1'b1;
        paddr     = 40'h100;
        idle(2);
        chk("pre_reset_busy", DW'(busy), DW'(1));
        #2 tb_rstn = 1'b0;
        #1;
        chk("midreset_busy", DW'(busy), '0);
        chk("midreset_tgt_req", DW'(tgt_req_valid), '0);
        chk("midreset_tgt_addr", DW'(tgt_req_addr), '0);
        chk("midreset_resp_valid", DW'(resp_valid), '0);
        chk("midreset_resp_error", DW'(resp_error), '0);
        chk("midreset_resp_data", resp_data, '0);
        chk("midreset_spurious_cnt", DW'(spurious_cnt), '0);
        chk("midreset_timeout_cnt", DW'(timeout_cnt), '0);
        idle(1);
        tb_rstn = 1'b1;
        idle(2);
        chk("post_reset_busy", DW'(busy), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/icache_refill_router.md
# icache_refill_router

Parametrised instruction-refill router between the icache miss port and NUM_TGT refill sources (bootrom, L2, further behavioural memories). It is the successor to the fixed bootrom/L2 response mux in the simulation top. It decodes each refill address against per-target base/mask windows and forwards the request to exactly one target. It then returns that target's line to the icache and reports unmapped addresses, timeouts and spurious responses. It also supports killing an outstanding refill on icache flush.

## Interface
Parameters:
- NUM_TGT, 2, number of refill targets (1..8).
- ADDR_W, 40, physical address width (drac_pkg::PHY_ADDR_SIZE).
- DATA_W, 128, refill line width (sargantana_icache_pkg::FETCH_WIDHT).
- TGT_BASE, {40'h0, 40'h0}, NUM_TGT×ADDR_W flattened, target i at bits [i*ADDR_W +: ADDR_W].
- TGT_MASK, {40'h0, 40'hFF_FF00_0000}, same packing as TGT_BASE.
  - Target 0 is the bootrom, covering addresses below 16 MiB.
  - Target 1 is L2 and acts as the catch-all.
- TIMEOUT_CYCLES, 1024, maximum WAIT cycles (≥2).

Ports:
- clk_i  in  1  clock.
- rstn_i  in  1  reset; asynchronous and active-low.
- req_valid_i  in  1  refill request pulse from icache.
- req_paddr_i  in  ADDR_W  refill address.
- kill_i  in  1  abandon the outstanding refill.
- busy_o  out  1  refill outstanding; icache must not request.
- tgt_req_valid_o  out  NUM_TGT  one-hot request pulse.
- tgt_req_addr_o  out  ADDR_W  registered address, shared by all targets.
- tgt_resp_valid_i  in  NUM_TGT  per-target response valid.
- tgt_resp_data_i  in  NUM_TGT×DATA_W  per-target line.
- resp_valid_o  out  1  line to icache, 1-cycle pulse.
- resp_data_o  out  DATA_W  line data; 0 on error.
- resp_error_o  out  1  qualifies resp_valid_o: unmapped address or timeout.
- spurious_cnt_o  out  16  saturating count of dropped responses.
- timeout_cnt_o  out  16  saturating count of timeouts.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP, DRAIN.
- IDLE:
  - On req_valid_i, register the address and decode hit[i] = ((paddr & TGT_MASK[i]) == TGT_BASE[i]).
  - Select the lowest i with hit[i]; go to ISSUE.
  - If no target hits, flag unmapped and go to RESP.
- ISSUE:
  - Pulse tgt_req_valid_o[sel] for one cycle; go to WAIT.
  - A response from the selected target in this cycle is captured and the FSM goes directly to RESP.
- WAIT:
  - Clear the timeout counter on entry; increment it each cycle with no selected response.
  - Selected response: capture the data and go to RESP.
  - Counter reaches TIMEOUT_CYCLES−1 with no response: set error, increment timeout_cnt_o, go to RESP.
- RESP: pulse resp_valid_o for one cycle with the data/error; go to IDLE.
- kill_i:
  - In ISSUE or WAIT: go to DRAIN. The target request pulse, if in ISSUE, is still sent.
  - In RESP: suppress resp_valid_o and go to IDLE.
  - In IDLE: ignored.
- DRAIN:
  - Discard the selected response, or wait out the timeout; go to IDLE.
  - Produces no resp_valid_o and does not increment timeout_cnt_o.
- Spurious responses:
  - Any tgt_resp_valid_i[j] asserted outside ISSUE/WAIT/DRAIN, or with j≠sel, is dropped.
  - Each such cycle increments spurious_cnt_o by popcount of the offending bits.
  - The counter saturates at 16'hFFFF.
- busy_o = (state ≠ IDLE).
- req_valid_i while busy_o is ignored and counted as spurious (+1).

## Timing
- Reset values:
  - State IDLE.
  - busy_o, tgt_req_valid_o, resp_valid_o, resp_error_o = 0.
  - resp_data_o, tgt_req_addr_o, both counters = 0.
- All outputs are registered; there is no combinational path from input to output.
- Mapped request: req_valid_i at cycle T → tgt_req_valid_o[sel] at T+1.
- Selected response at cycle R ≥ T+1 → resp_valid_o at R+1.
- Unmapped request: req_valid_i at T → resp_valid_o=1, resp_error_o=1 at T+2.
- Timeout: tgt_req at T+1, WAIT covers T+2..T+1+TIMEOUT_CYCLES, error response at T+2+TIMEOUT_CYCLES.
- A response arriving in the same cycle the counter expires wins: data is returned with no error and no timeout count.
- A response arriving after a timeout is counted as spurious.
- kill_i takes priority over a response arriving in the same cycle: the response is dropped without a spurious count.
- Reset asserted mid-refill returns all outputs immediately to their reset values. Counters clear.

## Test plan
- Bootrom fetch: req 0x100; tgt0 responds 3 cycles after its pulse with 0xA5…A5 → tgt_req_valid_o=2'b01 at T+1; resp_valid_o at T+5 with data 0xA5…A5, error 0; busy_o high T+1..T+5.
- L2 fetch: req 0x8000_0000; tgt1 responds in the ISSUE cycle → tgt_req_valid_o=2'b10; resp_valid_o at T+2.
- Unmapped address (TGT_MASK[1]=all-ones, TGT_BASE[1]=0x8000_0000): req 0x4000_0000 → no tgt pulse; resp_valid_o=1, resp_error_o=1, data 0 at T+2.
- Timeout (TIMEOUT_CYCLES=8): no response → error response at T+10, timeout_cnt_o=1; target then responds → spurious_cnt_o=1, no resp_valid_o.
- Kill: kill_i in the second WAIT cycle, tgt responds 2 cycles later → no resp_valid_o, busy_o falls the cycle after the response; next req is accepted normally.
- Spurious/edge cases:
  - tgt0 and tgt1 both respond while tgt1 is selected → tgt1 data returned, spurious_cnt_o +1.
  - Response coincident with timeout expiry → data returned, timeout_cnt_o unchanged.
  - rstn_i asserted in WAIT → all outputs 0 in the same cycle.
